uart_cmd_deframer: RTL and testbench

//  Byte-stream command deframer sitting directly downstream of the RS-232 RX stage.

---
 rtl/uart_cmd_deframer.sv | 148 ++++++++++++++
 tb/tb_uart_cmd_deframer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_deframer.sv
// Command deframer behind the RS-232 RX stage. It hunts for a sync byte, collects CMD/LEN/payload/XOR checksum,
// and holds each verified command for the tracker until it is acked.
`timescale 1ns/1ps

module uart_cmd_deframer #(
    parameter logic [7:0]  SYNC_BYTE = 8'h5A,
    parameter int unsigned MAX_LEN   = 16,
    parameter int unsigned AW        = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_ready,
    input  logic [7:0]    rx_data,
    input  logic          rx_eop,
    output logic          cmd_valid,
    output logic [7:0]    cmd_code,
    output logic [AW:0]   cmd_len,
    input  logic          cmd_ack,
    input  logic [AW-1:0] pay_addr,
    output logic [7:0]    pay_data,
    output logic          busy,
    output logic          err_csum,
    output logic          err_len,
    output logic          err_abort,
    output logic          err_overrun,
    output logic [7:0]    err_count
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned LW    = AW + 1;

    typedef enum logic [2:0] {IDLE, CMD, LEN, DATA, CSUM, HOLD} state_t;

    state_t        state, nextState;
    logic [7:0]    csum, csumNext;
    logic [AW-1:0] idx, idxNext;
    logic          latchCode, latchLen, wrEn;
    logic          eCsum, eLen, eAbort, eOverrun;
    logic [7:0]    mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        csumNext  = csum;
        idxNext   = idx;
        latchCode = 1'b0;
        latchLen  = 1'b0;
        wrEn      = 1'b0;
        eCsum     = 1'b0;
        eLen      = 1'b0;
        eAbort    = 1'b0;
        eOverrun  = 1'b0;
        case (state)
            IDLE: begin
                if (rx_ready && rx_data == SYNC_BYTE) nextState = CMD;
            end
            CMD: begin
                if (rx_ready) begin
                    latchCode = 1'b1;
                    csumNext  = rx_data;
                    nextState = LEN;
                end
            end
            LEN: begin
                if (rx_ready) begin
                    csumNext = csum ^ rx_data;
                    if ({1'b0, rx_data} > 9'(MAX_LEN)) begin
                        eLen      = 1'b1;
                        nextState = IDLE;
                    end else begin
                        latchLen  = 1'b1;
                        idxNext   = '0;
                        nextState = (rx_data == 8'h00) ? CSUM : DATA;
                    end
                end
            end
            DATA: begin
                if (rx_ready) begin
                    wrEn     = 1'b1;
                    csumNext = csum ^ rx_data;
                    idxNext  = idx + AW'(1);
                    if (LW'(idx) + LW'(1) == cmd_len) nextState = CSUM;
                end
            end
            CSUM: begin
                if (rx_ready) begin
                    if (rx_data == csum) nextState = HOLD;
                    else begin
                        eCsum     = 1'b1;
                        nextState = IDLE;
                    end
                end
            end
            HOLD: begin
                // Pending command owns the RAM and the header regs; incoming bytes are dropped.
                eOverrun = rx_ready;
                if (cmd_ack && cmd_valid) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
        // Gap strobe mid-frame aborts, unless a byte arrives in the same cycle.
        if ((state == CMD || state == LEN || state == DATA || state == CSUM) && rx_eop && !rx_ready) begin
            eAbort    = 1'b1;
            nextState = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            csum        <= '0;
            idx         <= '0;
            cmd_code    <= '0;
            cmd_len     <= '0;
            cmd_valid   <= 1'b0;
            busy        <= 1'b0;
            err_csum    <= 1'b0;
            err_len     <= 1'b0;
            err_abort   <= 1'b0;
            err_overrun <= 1'b0;
            err_count   <= '0;
            pay_data    <= '0;
        end else begin
            csum        <= csumNext;
            idx         <= idxNext;
            if (latchCode) cmd_code <= rx_data;
            if (latchLen)  cmd_len  <= LW'(rx_data);
            cmd_valid   <= (nextState == HOLD);
            busy        <= (nextState != IDLE);
            err_csum    <= eCsum;
            err_len     <= eLen;
            err_abort   <= eAbort;
            err_overrun <= eOverrun;
            if ((eCsum || eLen || eAbort || eOverrun) && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
            pay_data    <= mem[pay_addr];
        end
    end

    // Payload RAM needs no reset.
    always_ff @(posedge clk) begin
        if (wrEn) mem[idx] <= rx_data;
    end

endmodule

// File: tb/tb_uart_cmd_deframer.sv
// Scoreboard bench for uart_cmd_deframer: the stimulus pushes the expected commands and errors into queues,
// and separate monitors pop those entries and compare them with the DUT outputs.
`timescale 1ns/1ps

module tb_uart_cmd_deframer;

    localparam int unsigned AW = 4;
    localparam int ERR_CSUM = 0, ERR_LEN = 1, ERR_ABORT = 2, ERR_OVR = 3;

    logic          clk = 1'b0;
    logic          reset, rx_ready, rx_eop, cmd_ack;
    logic [7:0]    rx_data;
    logic [AW-1:0] pay_addr;
    logic          cmd_valid, busy, err_csum, err_len, err_abort, err_overrun;
    logic [7:0]    cmd_code, pay_data, err_count;
    logic [AW:0]   cmd_len;

    uart_cmd_deframer #(.SYNC_BYTE(8'h5A), .MAX_LEN(16), .AW(AW)) dut (
        .clk(clk), .reset(reset), .rx_ready(rx_ready), .rx_data(rx_data), .rx_eop(rx_eop),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_len(cmd_len), .cmd_ack(cmd_ack),
        .pay_addr(pay_addr), .pay_data(pay_data), .busy(busy),
        .err_csum(err_csum), .err_len(err_len), .err_abort(err_abort), .err_overrun(err_overrun),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]       code;
        logic [7:0]       len;
        logic [15:0][7:0] pay;
        logic [7:0]       hold;
    } cmd_t;

    int         checks = 0;
    int         errors = 0;
    cmd_t       expCmd[$];
    int         expErr[$];
    int         modelCount = 0;
    logic       monActive = 1'b0;
    logic [7:0] seq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Driver sits at posedge+1; one byte per clock.
    task automatic sendByte(input logic [7:0] b, input logic eop);
        rx_ready = 1'b1;
        rx_data  = b;
        rx_eop   = eop;
        @(posedge clk); #1;
        rx_ready = 1'b0;
        rx_eop   = 1'b0;
    endtask

    task automatic sendSeq(input int eopAt);
        for (int i = 0; i < seq.size(); i++) sendByte(seq[i], i == eopAt);
    endtask

    task automatic eopStrobe();
        rx_eop = 1'b1;
        @(posedge clk); #1;
        rx_eop = 1'b0;
    endtask

    task automatic expectFromSeq(input int hold);
        cmd_t e;
        e = '0;
        e.code = seq[1];
        e.len  = seq[2];
        for (int i = 0; i < int'(seq[2]); i++) e.pay[i] = seq[3 + i];
        e.hold = 8'(hold);
        expCmd.push_back(e);
    endtask

    task automatic waitIdle();
        int n = 0;
        while (!(expCmd.size() == 0 && expErr.size() == 0 && !monActive && !busy) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", 32'(n >= 400), 0);
    endtask

    task automatic waitValid();
        int n = 0;
        while (!cmd_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("valid_timeout", 32'(n >= 50), 0);
    endtask

    // Command monitor: checks header and payload, then acks after the requested hold time.
    initial begin : cmdMon
        cmd_t e;
        cmd_ack  = 1'b0;
        pay_addr = '0;
        forever begin
            @(negedge clk);
            if (!reset && cmd_valid) begin
                monActive = 1'b1;
                if (expCmd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cmd actual code=%0h len=%0d required none", cmd_code, cmd_len);
                end else begin
                    e = expCmd.pop_front();
                    repeat (int'(e.hold)) @(negedge clk);
                    chk("cmd_valid_hold", 32'(cmd_valid), 1);
                    chk("cmd_code", 32'(cmd_code), 32'(e.code));
                    chk("cmd_len", 32'(cmd_len), 32'(e.len));
                    for (int i = 0; i < int'(e.len); i++) begin
                        pay_addr = AW'(i);
                        @(negedge clk);
                        chk($sformatf("pay[%0d]", i), 32'(pay_data), 32'(e.pay[i]));
                    end
                end
                cmd_ack = 1'b1;
                @(negedge clk);
                cmd_ack = 1'b0;
                chk("valid_after_ack", 32'(cmd_valid), 0);
                chk("busy_after_ack", 32'(busy), 0);
                monActive = 1'b0;
            end
        end
    end

    // Error monitor: the pulse kind must match the queue head, and err_count must track a saturating model.
    initial begin : errMon
        int k;
        forever begin
            @(negedge clk);
            if (reset) modelCount = 0;
            else begin
                k = int'(err_csum) + int'(err_len) + int'(err_abort) + int'(err_overrun);
                if (k > 1) begin
                    checks++;
                    errors++;
                    $display("FAIL err_multi actual=%0d pulses required<=1", k);
                end else if (k == 1) begin
                    int got;
                    got = err_csum ? ERR_CSUM : err_len ? ERR_LEN : err_abort ? ERR_ABORT : ERR_OVR;
                    if (expErr.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_err actual kind=%0d required none", got);
                    end else chk("err_kind", 32'(got), 32'(expErr.pop_front()));
                    if (modelCount < 255) modelCount++;
                    chk("err_count", 32'(err_count), 32'(modelCount));
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] cs;
        reset = 1'b1; rx_ready = 1'b0; rx_eop = 1'b0; rx_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(cmd_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_errs", 32'({err_csum, err_len, err_abort, err_overrun}), 0);
        chk("rst_count", 32'(err_count), 0);
        chk("rst_code", 32'(cmd_code), 0);
        chk("rst_len", 32'(cmd_len), 0);
        chk("rst_pay", 32'(pay_data), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Garbage in IDLE is discarded silently.
        seq = '{8'h00, 8'h13, 8'hFF, 8'h01};
        sendSeq(-1);
        chk("idle_garbage_busy", 32'(busy), 0);
        waitIdle();

        // Test 1
        seq = '{8'h5A, 8'h01, 8'h02, 8'hAA, 8'h55, 8'hFC};
        expectFromSeq(2);
        sendSeq(-1);
        waitIdle();

        // Test 2: bad checksum
        seq = '{8'h5A, 8'h01, 8'h02, 8'hAA, 8'h55, 8'hFD};
        expErr.push_back(ERR_CSUM);
        sendSeq(-1);
        waitIdle();
        chk("t2_err_count", 32'(err_count), 1);
        chk("t2_valid", 32'(cmd_valid), 0);

        // Test 3: zero length, then LEN above the maximum
        seq = '{8'h5A, 8'h07, 8'h00, 8'h07};
        expectFromSeq(1);
        sendSeq(-1);
        waitIdle();
        seq = '{8'h5A, 8'h01, 8'h11};
        expErr.push_back(ERR_LEN);
        sendSeq(-1);
        waitIdle();

        // Boundary: LEN == MAX_LEN; the last payload byte arrives together with rx_eop
        seq = '{8'h5A, 8'h42, 8'h10};
        cs = 8'h42 ^ 8'h10;
        for (int i = 0; i < 16; i++) begin
            seq.push_back(8'(i * 9 + 3));
            cs ^= 8'(i * 9 + 3);
        end
        seq.push_back(cs);
        expectFromSeq(1);
        sendSeq(18);
        waitIdle();

        // Test 4: abort mid-frame, then a sync value inside the frame
        seq = '{8'h5A, 8'h01, 8'h02, 8'hAA};
        expErr.push_back(ERR_ABORT);
        sendSeq(-1);
        eopStrobe();
        waitIdle();
        seq = '{8'h5A, 8'h03, 8'h01, 8'h5A, 8'h58};
        expectFromSeq(1);
        sendSeq(-1);
        waitIdle();

        // Test 5: overrun in HOLD; rx_eop in HOLD ignored
        seq = '{8'h5A, 8'h01, 8'h02, 8'hAA, 8'h55, 8'hFC};
        expectFromSeq(20);
        sendSeq(-1);
        waitValid();
        eopStrobe();
        seq = '{8'h5A, 8'h09};
        expErr.push_back(ERR_OVR);
        expErr.push_back(ERR_OVR);
        sendSeq(-1);
        waitIdle();

        // Saturation of err_count
        for (int n = 0; n < 300; n++) begin
            seq = '{8'h5A, 8'h01, 8'h11};
            expErr.push_back(ERR_LEN);
            sendSeq(-1);
        end
        waitIdle();
        chk("count_saturated", 32'(err_count), 32'hFF);

        // Test 6: reset during DATA
        seq = '{8'h5A, 8'h10, 8'h03, 8'h11};
        sendSeq(-1);
        chk("t6_in_frame_busy", 32'(busy), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_code", 32'(cmd_code), 0);
        chk("t6_len", 32'(cmd_len), 0);
        chk("t6_count", 32'(err_count), 0);
        chk("t6_valid", 32'(cmd_valid), 0);
        chk("t6_pay", 32'(pay_data), 0);
        reset = 1'b0;
        seq = '{8'h5A, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13};
        expectFromSeq(1);
        sendSeq(4);
        waitIdle();

        chk("cmdq_empty", 32'(expCmd.size()), 0);
        chk("errq_empty", 32'(expErr.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
